// File: rtl/max_parity_arbiter_if.sv
// Bundle for max_parity_arbiter: per-requester operand offers with grant pulses,
// plus the valid/ready response channel toward the result consumer.
interface max_parity_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 5,
    parameter int RES_W = 32,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_a;
    logic [N_REQ*DW-1:0] req_b;
    logic [N_REQ-1:0]    gnt;
    logic                busy;
    logic                resp_valid;
    logic                resp_ready;
    logic [ID_W-1:0]     resp_id;
    logic [RES_W-1:0]    resp_result;
    logic                resp_balance;

    modport master (
        output req, req_a, req_b, resp_ready,
        input  gnt, busy, resp_valid, resp_id, resp_result, resp_balance
    );

    modport slave (
        input  req, req_a, req_b, resp_ready,
        output gnt, busy, resp_valid, resp_id, resp_result, resp_balance
    );
endinterface

// File: rtl/max_parity_arbiter.sv
// Round-robin arbiter feeding one shared max/parity datapath; returns the
// sign-extended larger operand and its even-parity flag tagged with the requester id.
//
// state   | meaning
// IDLE    | waiting for any req; grant and capture operands of the round-robin winner
// COMPUTE | registered operands -> max, balance, sign-extended result
// RESP    | response presented until resp_ready, then pointer advances past winner
module max_parity_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 5,
    parameter int RES_W = 32,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    max_parity_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COMPUTE, RESP} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cap_id;
    logic [ID_W-1:0] win;
    logic            found;
    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [DW-1:0]   max_val;

    // First set request at or above the pointer, wrapping past N_REQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && bus.req[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

    assign bus.gnt        = (state == IDLE && found && !rst) ? (N_REQ'(1) << win) : '0;
    assign bus.busy       = (state != IDLE);
    assign bus.resp_valid = (state == RESP);
    assign max_val        = (op_a > op_b) ? op_a : op_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            ptr              <= '0;
            cap_id           <= '0;
            op_a             <= '0;
            op_b             <= '0;
            bus.resp_id      <= '0;
            bus.resp_result  <= '0;
            bus.resp_balance <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a   <= bus.req_a[int'(win)*DW +: DW];
                        op_b   <= bus.req_b[int'(win)*DW +: DW];
                        cap_id <= win;
                        state  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    bus.resp_id      <= cap_id;
                    bus.resp_result  <= {{(RES_W-DW){max_val[DW-1]}}, max_val};
                    bus.resp_balance <= ~^max_val;
                    state            <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        // Winner drops to lowest priority for the next round.
                        ptr   <= (cap_id == ID_W'(N_REQ-1)) ? '0 : cap_id + 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_max_parity_arbiter.sv
// Self-checking bench for max_parity_arbiter: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_max_parity_arbiter;
    localparam int N_REQ = 4;
    localparam int DW    = 5;
    localparam int RES_W = 32;
    localparam int ID_W  = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    max_parity_arbiter_if #(.N_REQ(N_REQ), .DW(DW), .RES_W(RES_W), .ID_W(ID_W)) bus ();

    max_parity_arbiter #(.N_REQ(N_REQ), .DW(DW), .RES_W(RES_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: transaction view with cycle stamps.
    bit            m_free = 1'b1;
    int            m_ptr  = 0;
    int            m_id   = 0;
    int            m_gcyc = 0;
    int            m_hcyc = -1;
    int            cyc    = 0;
    logic [DW-1:0] m_a, m_b;
    int            grant_log[$];
    int            grant_cyc[$];
    logic [63:0]   obs_id, obs_res, obs_bal;

    function automatic logic [RES_W-1:0] ref_result(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int v;
        v = (a > b) ? int'(a) : int'(b);
        if (v >= 2**(DW-1)) v = v - 2**DW;
        return RES_W'(v);
    endfunction

    function automatic logic ref_balance(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] mx;
        mx = (a > b) ? a : b;
        return ($countones(mx) % 2) == 0;
    endfunction

    function automatic logic [N_REQ*DW-1:0] put(input int idx, input logic [DW-1:0] v);
        logic [N_REQ*DW-1:0] r;
        r = '0;
        r[idx*DW +: DW] = v;
        return r;
    endfunction

    task automatic model_check();
        logic [N_REQ-1:0] eg;
        bit free_next;
        bit found;
        eg = '0;
        free_next = m_free;
        found = 1'b0;
        if (m_free) begin
            for (int k = 0; k < N_REQ; k++) begin
                int idx;
                idx = (m_ptr + k) % N_REQ;
                if (!found && bus.req[idx]) begin
                    found = 1'b1;
                    m_id  = idx;
                end
            end
            if (found) begin
                eg[m_id]  = 1'b1;
                m_a       = bus.req_a[m_id*DW +: DW];
                m_b       = bus.req_b[m_id*DW +: DW];
                m_gcyc    = cyc;
                free_next = 1'b0;
            end
            check("gnt_idle", bus.gnt, eg);
            check("busy_idle", bus.busy, 0);
            check("valid_idle", bus.resp_valid, 0);
        end else if (cyc == m_gcyc + 1) begin
            check("gnt_compute", bus.gnt, 0);
            check("busy_compute", bus.busy, 1);
            check("valid_compute", bus.resp_valid, 0);
        end else begin
            check("gnt_resp", bus.gnt, 0);
            check("busy_resp", bus.busy, 1);
            check("valid_resp", bus.resp_valid, 1);
            check("resp_id", bus.resp_id, m_id);
            check("resp_result", bus.resp_result, ref_result(m_a, m_b));
            check("resp_balance", bus.resp_balance, ref_balance(m_a, m_b));
            obs_id  = bus.resp_id;
            obs_res = bus.resp_result;
            obs_bal = bus.resp_balance;
            if (bus.resp_ready) begin
                m_ptr     = (m_id + 1) % N_REQ;
                m_hcyc    = cyc;
                free_next = 1'b1;
            end
        end
        if (bus.gnt != 0) begin
            int gi;
            gi = -1;
            for (int k = 0; k < N_REQ; k++)
                if (bus.gnt == (N_REQ'(1) << k)) gi = k;
            grant_log.push_back(gi);
            grant_cyc.push_back(cyc);
        end
        m_free = free_next;
        cyc++;
    endtask

    task automatic tick(input logic [N_REQ-1:0] r, input logic [N_REQ*DW-1:0] a,
                        input logic [N_REQ*DW-1:0] b, input logic rdy);
        bus.req        = r;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.resp_ready = rdy;
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_gnt"}, bus.gnt, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_valid"}, bus.resp_valid, 0);
        check({tag, "_id"}, bus.resp_id, 0);
        check({tag, "_result"}, bus.resp_result, 0);
        check({tag, "_balance"}, bus.resp_balance, 0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check_zero_outputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_free = 1'b1;
        m_ptr  = 0;
    endtask

    initial begin
        logic [N_REQ-1:0] rq;
        rst            = 1'b0;
        bus.req        = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        check_zero_outputs("por");
        @(posedge clk);
        #1;
        apply_reset();

        // Single request, even popcount
        tick(4'b0001, put(0, 5'd9), put(0, 5'd6), 1'b1);
        tick(4'b0000, '0, '0, 1'b1);
        tick(4'b0000, '0, '0, 1'b1);
        tick(4'b0000, '0, '0, 1'b1);
        check("t1_id", obs_id, 0);
        check("t1_result", obs_res, 32'h0000_0009);
        check("t1_balance", obs_bal, 1);

        // Sign extension, odd parity
        tick(4'b0100, put(2, 5'b10110), put(2, 5'd3), 1'b1);
        tick(4'b0000, '0, '0, 1'b1);
        tick(4'b0000, '0, '0, 1'b1);
        tick(4'b0000, '0, '0, 1'b1);
        check("t2_id", obs_id, 2);
        check("t2_result", obs_res, 32'hFFFF_FFF6);
        check("t2_balance", obs_bal, 0);

        // Zero and ties
        tick(4'b0010, put(1, 5'd0), put(1, 5'd0), 1'b1);
        repeat (3) tick(4'b0000, '0, '0, 1'b1);
        check("t3_zero_result", obs_res, 32'h0000_0000);
        check("t3_zero_balance", obs_bal, 1);
        tick(4'b0010, put(1, 5'b11111), put(1, 5'b11111), 1'b1);
        repeat (3) tick(4'b0000, '0, '0, 1'b1);
        check("t3_tie_result", obs_res, 32'hFFFF_FFFF);
        check("t3_tie_balance", obs_bal, 0);

        // Round-robin with every requester held high
        apply_reset();
        grant_log.delete();
        grant_cyc.delete();
        repeat (18) tick(4'b1111, N_REQ*DW'($urandom), N_REQ*DW'($urandom), 1'b1);
        check("rr_count", grant_log.size(), 6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
            check("rr_order", grant_log[i], i % N_REQ);
            if (i > 0) check("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 3);
        end

        // Backpressure
        grant_log.delete();
        grant_cyc.delete();
        tick(4'b1000, put(3, 5'd7), put(3, 5'd20), 1'b0);
        tick(4'b0000, put(3, 5'd1), put(3, 5'd1), 1'b0);
        repeat (5) tick(4'b0001, put(0, 5'd3), '0, 1'b0);
        check("bp_no_extra_gnt", grant_log.size(), 1);
        tick(4'b0001, put(0, 5'd3), '0, 1'b1);
        check("bp_result", obs_res, 32'hFFFF_FFF4);
        check("bp_id", obs_id, 3);
        tick(4'b0001, put(0, 5'd3), '0, 1'b1);
        check("bp_gnt_count", grant_log.size(), 2);
        if (grant_cyc.size() == 2) check("bp_gnt_after_hs", grant_cyc[1], m_hcyc + 1);
        repeat (3) tick(4'b0000, '0, '0, 1'b1);

        // Reset while requester 2 is in COMPUTE
        tick(4'b0100, put(2, 5'd17), put(2, 5'd2), 1'b1);
        bus.req = '0;
        rst     = 1'b1;
        #1;
        check_zero_outputs("midrst");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_free = 1'b1;
        m_ptr  = 0;
        grant_log.delete();
        tick(4'b0110, put(1, 5'd4) | put(2, 5'd4), '0, 1'b1);
        check("midrst_first_gnt", grant_log.size() > 0 ? grant_log[0] : -1, 1);
        repeat (3) tick(4'b0000, '0, '0, 1'b1);

        // Random traffic
        rq = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rq = N_REQ'($urandom);
            tick(rq, N_REQ*DW'($urandom), N_REQ*DW'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
